// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the three-wire serial link receiver.
// This file holds the FSM state encodings and the default frame width and bit order.
package serial_receiver_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV    = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam int DEFAULT_WIDTH     = 8;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_receiver_link_sync_edge.sv
// Brings one asynchronous link wire into the clk domain.
// It provides the synchronised level plus single-cycle rise and fall pulses.
module serial_receiver_link_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   level_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
            level_prev <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
            level_prev <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign level = sync_chain[SYNC_STAGES-1];
    assign rise  = level & ~level_prev;
    assign fall  = ~level & level_prev;

endmodule

// File: rtl/serial_receiver.sv
// Receive side of the three-wire serial link (transmission, link_clock, link_data).
// It assembles WIDTH-bit frames and hands them out through a valid/ready hold register.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = DEFAULT_MSB_FIRST,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             transmission,
    input  logic             link_clock,
    input  logic             link_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_error,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
        if (MSB_FIRST)
            return {sr[WIDTH-2:0], b};
        else
            return {b, sr[WIDTH-1:1]};
    endfunction

    logic trans_lvl, trans_rise, trans_fall;
    logic lclk_lvl, lclk_rise, lclk_fall;
    logic data_lvl, data_rise, data_fall;

    serial_receiver_link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trans (
        .clk(clk), .rst_n(rst_n), .din(transmission),
        .level(trans_lvl), .rise(trans_rise), .fall(trans_fall)
    );

    serial_receiver_link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lclk (
        .clk(clk), .rst_n(rst_n), .din(link_clock),
        .level(lclk_lvl), .rise(lclk_rise), .fall(lclk_fall)
    );

    serial_receiver_link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .din(link_data),
        .level(data_lvl), .rise(data_rise), .fall(data_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{lclk_lvl, lclk_fall, data_rise, data_fall};

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_upd;
    logic [TMR_W-1:0] timer;

    // A transmission fall in the same cycle as a link-clock edge is judged on the updated count.
    assign cnt_upd = lclk_rise ? bit_cnt + CNT_W'(1) : bit_cnt;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (trans_rise) begin
                        state     <= ST_RECV;
                        bit_cnt   <= '0;
                        timer     <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_RECV: begin
                    if (lclk_rise && bit_cnt == FULL_CNT) begin
                        frame_error <= 1'b1;
                        state       <= ST_DRAIN;
                    end else begin
                        if (lclk_rise) begin
                            shift_reg <= shift_in(shift_reg, data_lvl);
                            bit_cnt   <= cnt_upd;
                            timer     <= '0;
                        end else if (timer != '1) begin
                            timer <= timer + TMR_W'(1);
                        end

                        if (trans_fall) begin
                            if (cnt_upd == FULL_CNT) begin
                                state <= ST_DELIVER;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= ST_IDLE;
                            end
                        end else if (!lclk_rise && timer == TMR_LAST) begin
                            frame_error <= 1'b1;
                            state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DELIVER: begin
                    state <= ST_IDLE;
                    if (out_valid && !out_ready)
                        overrun <= 1'b1;
                end
                ST_DRAIN: begin
                    if (!trans_lvl)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A consumer handshake and a new delivery in the same cycle keep out_valid high.
            if (state == ST_DELIVER && (!out_valid || out_ready)) begin
                out_data  <= shift_reg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
